apb_rr_master: RTL and testbench

- Round-robin APB master that shares one APB slave (memory-backed register slave) between NREQ internal requesters.
- Arbitrates pending requests, sequences the APB SETUP/ACCESS phases, waits for PREADY, returns read data and a per-requester completion pulse.
- Aborts a transfer that exceeds a bounded wait.
- Sits between the bus-side requesters and the slave's PSEL/PENABLE/PWRITE/PRWADDR/PRWDATA/PRDATA1/PREADY interface.

---
 rtl/apb_rr_pkg.sv | 37 +++
 rtl/apb_rr_master_arbiter.sv | 38 +++
 rtl/apb_rr_master.sv | 160 ++++++++++++++++
 tb/tb_apb_rr_master.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_rr_pkg.sv
// Shared types and helpers for the round-robin APB master: FSM state encoding,
// requester index width and the rotating first-set-bit pick.
package apb_rr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Index width covers the largest legal requester count so the pick
    // function can be shared by every parameterisation.
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = $clog2(MAX_REQ);

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } pick_t;

    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   ptr,
                                      input int                 nreq);
        pick_t p;
        int    j;
        p = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = (int'(ptr) + k) % nreq;
            if (k < nreq && !p.valid && req[j]) begin
                p.valid = 1'b1;
                p.idx   = IDX_W'(j);
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/apb_rr_master_arbiter.sv
// Round-robin arbiter: combinational pick starting at a registered pointer,
// which moves past the winner when its transfer completes.
module rr_arbiter
    import apb_rr_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [NREQ-1:0]  i_req,
    input  logic             i_adv,
    input  logic [IDX_W-1:0] i_winner,
    output logic             o_valid,
    output logic [IDX_W-1:0] o_idx
);

    logic [IDX_W-1:0]   r_ptr;
    logic [MAX_REQ-1:0] w_req_pad;
    pick_t              w_pick;

    always_comb begin
        w_req_pad             = '0;
        w_req_pad[NREQ-1:0]   = i_req;
    end

    assign w_pick  = rr_pick(w_req_pad, r_ptr, NREQ);
    assign o_valid = w_pick.valid;
    assign o_idx   = w_pick.idx;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_ptr <= '0;
        end else if (i_adv) begin
            r_ptr <= (i_winner == IDX_W'(NREQ - 1)) ? '0 : i_winner + 1'b1;
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// APB master sharing one slave between NREQ requesters: round-robin grant,
// SETUP/ACCESS sequencing, read-data return and a bounded PREADY wait.
module apb_rr_master
    import apb_rr_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  req_write,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  done,
    output logic             err,
    output logic [DW-1:0]    rdata,
    output logic             PSEL,
    output logic             PENABLE,
    output logic             PWRITE,
    output logic [AW-1:0]    PRWADDR,
    output logic [DW-1:0]    PRWDATA,
    input  logic [DW-1:0]    PRDATA1,
    input  logic             PREADY
);

    localparam int               CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_done;
    logic             r_err;
    logic [DW-1:0]    r_rdata;
    logic             r_pwrite;
    logic [AW-1:0]    r_paddr;
    logic [DW-1:0]    r_pwdata;

    logic             w_pick_valid;
    logic [IDX_W-1:0] w_pick_idx;
    logic             w_start;
    logic             w_end;
    logic             w_tmo;
    logic [NREQ-1:0]  w_pick_oh;
    logic [NREQ-1:0]  w_cur_oh;
    logic             w_sel_write;
    logic [AW-1:0]    w_sel_addr;
    logic [DW-1:0]    w_sel_wdata;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .i_req    (req),
        .i_adv    (w_end),
        .i_winner (r_idx),
        .o_valid  (w_pick_valid),
        .o_idx    (w_pick_idx)
    );

    always_comb begin
        w_pick_oh   = '0;
        w_cur_oh    = '0;
        w_sel_write = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_pick_oh[i] = (w_pick_idx == IDX_W'(i));
            w_cur_oh[i]  = (r_idx == IDX_W'(i));
            if (w_pick_idx == IDX_W'(i)) begin
                w_sel_write = req_write[i];
                w_sel_addr  = req_addr[i*AW +: AW];
                w_sel_wdata = req_wdata[i*DW +: DW];
            end
        end
    end

    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        w_end   = 1'b0;
        w_tmo   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_start = 1'b1;
                    w_next  = SETUP;
                end
            end
            SETUP: w_next = ACCESS;
            ACCESS: begin
                if (PREADY) begin
                    w_end  = 1'b1;
                    w_next = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_end  = 1'b1;
                    w_tmo  = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_gnt    <= '0;
            r_done   <= '0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_pwrite <= 1'b0;
            r_paddr  <= '0;
            r_pwdata <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= '0;
            r_err   <= 1'b0;
            if (w_start) begin
                r_idx    <= w_pick_idx;
                r_gnt    <= w_pick_oh;
                r_pwrite <= w_sel_write;
                r_paddr  <= w_sel_addr;
                r_pwdata <= w_sel_wdata;
            end
            if (r_state == SETUP) begin
                r_cnt <= '0;
            end else if (r_state == ACCESS && !PREADY) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // A timed-out read leaves the previous read data in place.
            if (w_end) begin
                r_gnt  <= '0;
                r_done <= w_cur_oh;
                r_err  <= w_tmo;
                if (!w_tmo && !r_pwrite) begin
                    r_rdata <= PRDATA1;
                end
            end
        end
    end

    assign PSEL    = (r_state != IDLE);
    assign PENABLE = (r_state == ACCESS);
    assign PWRITE  = r_pwrite;
    assign PRWADDR = r_paddr;
    assign PRWDATA = r_pwdata;
    assign gnt     = r_gnt;
    assign done    = r_done;
    assign err     = r_err;
    assign rdata   = r_rdata;

endmodule

// File: tb/tb_apb_rr_master.sv
// Bench for apb_rr_master: memory slave with registered PREADY, a cycle-level
// behavioural model compared every cycle, and directed literal expectations.
module tb_apb_rr_master;

    localparam int NREQ    = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;
    localparam int TIMEOUT = 4;

    logic               PCLK   = 1'b0;
    logic               PRESET = 1'b1;
    logic [NREQ-1:0]    req       = '0;
    logic [NREQ-1:0]    req_write = '0;
    logic [NREQ*AW-1:0] req_addr  = '0;
    logic [NREQ*DW-1:0] req_wdata = '0;
    logic [NREQ-1:0]    gnt, done;
    logic               err;
    logic [DW-1:0]      rdata;
    logic               PSEL, PENABLE, PWRITE;
    logic [AW-1:0]      PRWADDR;
    logic [DW-1:0]      PRWDATA;
    logic [DW-1:0]      PRDATA1;
    logic               PREADY = 1'b0;
    logic               stall  = 1'b0;
    logic [DW-1:0]      mem [16] = '{default: '0};

    int errors = 0;
    int checks = 0;

    always #5 PCLK = ~PCLK;

    apb_rr_master #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PRWADDR   (PRWADDR),
        .PRWDATA   (PRWDATA),
        .PRDATA1   (PRDATA1),
        .PREADY    (PREADY)
    );

    // Slave: one wait state, PREADY registered, writes committed on the ready edge.
    assign PRDATA1 = mem[PRWADDR[3:0]];
    always @(posedge PCLK) begin
        if (PRESET) begin
            PREADY <= 1'b0;
        end else begin
            if (PSEL && PENABLE && PREADY && PWRITE) mem[PRWADDR[3:0]] <= PRWDATA;
            PREADY <= PSEL && PENABLE && !PREADY && !stall;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: age counts cycles since grant (0 = setup, >=1 = access).
    logic [NREQ-1:0] e_gnt, e_done;
    logic            e_err, e_pwrite;
    logic [DW-1:0]   e_rdata, e_wdata;
    logic [AW-1:0]   e_addr;
    int              m_age, m_own, m_ptr;
    logic            m_on;

    initial begin
        m_on = 1'b0; m_age = -1; m_own = 0; m_ptr = 0;
        e_gnt = '0; e_done = '0; e_err = 1'b0; e_pwrite = 1'b0;
        e_rdata = '0; e_wdata = '0; e_addr = '0;
        forever begin
            @(negedge PCLK);
            if (m_on) begin
                chk("gnt", gnt, e_gnt);
                chk("done", done, e_done);
                chk("err", err, e_err);
                chk("rdata", rdata, e_rdata);
                chk("PSEL", PSEL, m_age >= 0);
                chk("PENABLE", PENABLE, m_age >= 1);
                chk("PWRITE", PWRITE, e_pwrite);
                chk("PRWADDR", PRWADDR, e_addr);
                chk("PRWDATA", PRWDATA, e_wdata);
            end
            if (PRESET) begin
                m_on = 1'b1; m_age = -1; m_ptr = 0;
                e_gnt = '0; e_done = '0; e_err = 1'b0; e_pwrite = 1'b0;
                e_rdata = '0; e_wdata = '0; e_addr = '0;
            end else if (m_on) begin
                e_done = '0;
                e_err  = 1'b0;
                if (m_age < 0) begin
                    for (int k = 0; k < NREQ; k++) begin
                        int i;
                        i = (m_ptr + k) % NREQ;
                        if (m_age < 0 && req[i]) begin
                            m_own    = i;
                            m_age    = 0;
                            e_gnt    = '0;
                            e_gnt[i] = 1'b1;
                            e_pwrite = req_write[i];
                            e_addr   = req_addr[i*AW +: AW];
                            e_wdata  = req_wdata[i*DW +: DW];
                        end
                    end
                end else if (m_age == 0) begin
                    m_age = 1;
                end else if (PREADY || m_age == TIMEOUT) begin
                    if (PREADY && !e_pwrite) e_rdata = mem[e_addr[3:0]];
                    e_done        = '0;
                    e_done[m_own] = 1'b1;
                    e_err         = !PREADY;
                    e_gnt         = '0;
                    m_ptr         = (m_own + 1) % NREQ;
                    m_age         = -1;
                end else begin
                    m_age++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge PCLK);
        #2;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]        = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req[i]              = 1'b1;
    endtask

    task automatic wait_done(input int lim, output logic [NREQ-1:0] d, output int n, output int pen);
        d = '0; n = 0; pen = 0;
        while (n < lim && d == '0) begin
            tick();
            n++;
            if (PENABLE) pen++;
            d = done;
        end
        if (d == '0) chk("done_wait_expired", 0, 1);
    endtask

    logic [NREQ-1:0] d;
    int              n, pen;
    int              order [4];

    initial begin
        #100000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        PRESET = 1'b0;
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_paddr", PRWADDR, 0);

        // Write 0xDEADBEEF to address 5 from requester 0
        set_req(0, 1'b1, 32'd5, 32'hDEADBEEF);
        tick();
        chk("t1_gnt", gnt, 2'b01);
        chk("t1_psel", PSEL, 1);
        chk("t1_penable_setup", PENABLE, 0);
        tick();
        chk("t1_penable_access", PENABLE, 1);
        wait_done(10, d, n, pen);
        chk("t1_done", d, 2'b01);
        chk("t1_latency", n, 2);
        chk("t1_err", err, 0);
        req[0] = 1'b0;
        chk("t1_mem5", mem[5], 32'hDEADBEEF);
        tick();
        chk("t1_done_pulse", done, 0);

        // Read address 5 from requester 1
        set_req(1, 1'b0, 32'd5, 32'h0);
        wait_done(10, d, n, pen);
        chk("t2_done", d, 2'b10);
        chk("t2_rdata", rdata, 32'hDEADBEEF);
        chk("t2_pwrite", PWRITE, 0);
        req[1] = 1'b0;
        repeat (3) tick();
        chk("t2_rdata_held", rdata, 32'hDEADBEEF);

        // Slave never ready: bounded wait then error
        stall = 1'b1;
        set_req(0, 1'b0, 32'd3, 32'h0);
        wait_done(20, d, n, pen);
        chk("t4_done", d, 2'b01);
        chk("t4_access_cycles", pen, 4);
        chk("t4_err", err, 1);
        chk("t4_rdata_kept", rdata, 32'hDEADBEEF);
        chk("t4_psel_off", PSEL, 0);
        req[0] = 1'b0;
        tick();
        chk("t4_err_pulse", err, 0);
        stall = 1'b0;

        // Address change after grant is ignored
        set_req(0, 1'b1, 32'd5, 32'h12345678);
        tick();
        req_addr[0 +: AW]  = 32'd9;
        req_wdata[0 +: DW] = 32'h0;
        tick();
        chk("t6_addr_a1", PRWADDR, 5);
        tick();
        chk("t6_addr_a2", PRWADDR, 5);
        wait_done(10, d, n, pen);
        chk("t6_done", d, 2'b01);
        req[0] = 1'b0;
        chk("t6_mem5", mem[5], 32'h12345678);
        chk("t6_mem9", mem[9], 32'h0);

        // Persistent dual requests after reset alternate
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        chk("t3_rst_rdata", rdata, 0);
        set_req(0, 1'b0, 32'd9, 32'h0);
        set_req(1, 1'b0, 32'd5, 32'h0);
        for (int t = 0; t < 4; t++) begin
            wait_done(10, d, n, pen);
            order[t] = (d == 2'b01) ? 0 : (d == 2'b10) ? 1 : 9;
        end
        req = '0;
        chk("t3_order0", order[0], 0);
        chk("t3_order1", order[1], 1);
        chk("t3_order2", order[2], 0);
        chk("t3_order3", order[3], 1);
        chk("t3_rdata", rdata, 32'h12345678);

        // Reset in the middle of an ACCESS phase
        set_req(1, 1'b0, 32'd9, 32'h0);
        tick();
        tick();
        chk("t5_in_access", PENABLE, 1);
        PRESET = 1'b1;
        tick();
        PRESET = 1'b0;
        chk("t5_gnt", gnt, 0);
        chk("t5_done", done, 0);
        chk("t5_psel", PSEL, 0);
        chk("t5_penable", PENABLE, 0);
        chk("t5_paddr", PRWADDR, 0);
        tick();
        chk("t5_regrant", gnt, 2'b10);
        wait_done(10, d, n, pen);
        chk("t5_done_after", d, 2'b10);
        chk("t5_rdata", rdata, 32'h0);
        req = '0;
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
